// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, state/source enums and lane helper for the SPI tx arbiter
package spi_pkg;

  localparam logic [31:0] ID_WORD_DEFAULT = 32'h534C4131;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORD = 2'd1,
    ST_META = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_ID     = 2'd0,
    SRC_DATAIN = 2'd1,
    SRC_META   = 2'd2,
    SRC_MEM    = 2'd3
  } src_e;

  // Index of the lowest set bit of a keep mask; 0 when the mask is empty.
  function automatic logic [1:0] first_lane(input logic [3:0] keep);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (keep[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_word_serializer.sv
// rtl/spi_word_serializer.sv - 32-bit holding register plus keep mask emitted as a byte stream
module spi_word_serializer
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  keep_i,
  input  logic        tready_i,
  output logic        tvalid_o,
  output logic [7:0]  tdata_o,
  output logic        done_o
);

  logic [31:0] data_q, data_d;
  logic [3:0]  keep_q, keep_d;
  logic        active_q, active_d;
  logic        valid_q, valid_d;
  logic [7:0]  tdata_q, tdata_d;
  logic [1:0]  lane;
  logic        advance;

  assign lane    = first_lane(keep_q);
  // The output register may take a new byte when empty or when its byte is being accepted.
  assign advance = active_q && (!valid_q || tready_i);
  assign done_o  = advance && (keep_q == 4'h0);

  assign tvalid_o = valid_q;
  assign tdata_o  = tdata_q;

  always_comb begin
    data_d   = data_q;
    keep_d   = keep_q;
    active_d = active_q;
    valid_d  = valid_q;
    tdata_d  = tdata_q;
    if (clear_i) begin
      keep_d   = 4'h0;
      active_d = 1'b0;
      valid_d  = 1'b0;
    end else if (load_i) begin
      data_d   = data_i;
      keep_d   = keep_i;
      active_d = 1'b1;
      valid_d  = 1'b0;
    end else if (advance) begin
      if (keep_q != 4'h0) begin
        tdata_d = data_q[{lane, 3'b000} +: 8];
        valid_d = 1'b1;
        keep_d  = keep_q & ~(4'b0001 << lane);
      end else begin
        valid_d  = 1'b0;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= 32'h0;
      keep_q   <= 4'h0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      tdata_q  <= 8'h00;
    end else begin
      data_q   <= data_d;
      keep_q   <= keep_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      tdata_q  <= tdata_d;
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - arbitrates ID, dataIn, metadata and memory responses onto one SPI byte stream
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter logic [31:0] ID_WORD = ID_WORD_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        query_id,
  input  logic        query_dataIn,
  input  logic        query_metadata,
  input  logic [31:0] dataIn,
  input  logic        meta_tvalid,
  input  logic [7:0]  meta_tdata,
  input  logic        meta_tlast,
  output logic        meta_tready,
  input  logic        mem_tvalid,
  input  logic [31:0] mem_tdata,
  input  logic [3:0]  mem_tkeep,
  output logic        mem_tready,
  output logic        tx_tvalid,
  output logic [7:0]  tx_tdata,
  input  logic        tx_tready,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        id_pend_q, id_pend_d;
  logic        din_pend_q, din_pend_d;
  logic        meta_pend_q, meta_pend_d;
  logic        id_clr, din_clr, meta_clr;
  logic        any_pend;
  src_e        src;

  logic        ser_load;
  logic [31:0] ser_data;
  logic [3:0]  ser_keep;
  logic        ser_tvalid;
  logic [7:0]  ser_tdata;
  logic        ser_done;

  logic        mvalid_q, mvalid_d;
  logic [7:0]  mdata_q, mdata_d;
  logic        mlast_q, mlast_d;
  logic        meta_exit;
  logic        mem_fire;

  assign any_pend = id_pend_q || din_pend_q || meta_pend_q;
  assign busy     = (state_q != ST_IDLE) || any_pend;

  always_comb begin
    src = SRC_MEM;
    if (meta_pend_q) src = SRC_META;
    if (din_pend_q)  src = SRC_DATAIN;
    if (id_pend_q)   src = SRC_ID;
  end

  // Memory words only flow when nothing registered is pending, so a coincident query waits its turn.
  assign mem_tready = !rst && !flush && (state_q == ST_IDLE) && !any_pend;
  assign mem_fire   = mem_tready && mem_tvalid;

  // Once the tlast byte sits in the skid register, nothing further is taken from the meta stream.
  assign meta_tready = !rst && !flush && (state_q == ST_META) &&
                       !(mvalid_q && mlast_q) && (tx_tready || !mvalid_q);
  assign meta_exit   = (state_q == ST_META) && mvalid_q && mlast_q && tx_tready;

  assign tx_tvalid = ser_tvalid || mvalid_q;
  assign tx_tdata  = mvalid_q ? mdata_q : ser_tdata;

  always_comb begin
    state_d  = state_q;
    ser_load = 1'b0;
    ser_data = mem_tdata;
    ser_keep = mem_tkeep;
    id_clr   = 1'b0;
    din_clr  = 1'b0;
    meta_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          case (src)
            SRC_ID: begin
              ser_load = 1'b1;
              ser_data = ID_WORD;
              ser_keep = 4'hF;
              id_clr   = 1'b1;
              state_d  = ST_WORD;
            end
            SRC_DATAIN: begin
              ser_load = 1'b1;
              ser_data = dataIn;
              ser_keep = 4'hF;
              din_clr  = 1'b1;
              state_d  = ST_WORD;
            end
            SRC_META: begin
              meta_clr = 1'b1;
              state_d  = ST_META;
            end
            default: begin
            end
          endcase
        end else if (mem_fire) begin
          ser_load = 1'b1;
          state_d  = ST_WORD;
        end
      end
      ST_WORD: if (ser_done) state_d = ST_IDLE;
      ST_META: if (meta_exit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // A pulse while its flag is already set is absorbed; a flush discards both flag and pulse.
  assign id_pend_d   = !flush && (id_pend_q   ? !id_clr   : query_id);
  assign din_pend_d  = !flush && (din_pend_q  ? !din_clr  : query_dataIn);
  assign meta_pend_d = !flush && (meta_pend_q ? !meta_clr : query_metadata);

  always_comb begin
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mlast_d  = mlast_q;
    if (flush) begin
      mvalid_d = 1'b0;
    end else if (meta_tready && meta_tvalid) begin
      mvalid_d = 1'b1;
      mdata_d  = meta_tdata;
      mlast_d  = meta_tlast;
    end else if (tx_tready) begin
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      id_pend_q   <= 1'b0;
      din_pend_q  <= 1'b0;
      meta_pend_q <= 1'b0;
      mvalid_q    <= 1'b0;
      mdata_q     <= 8'h00;
      mlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_pend_q   <= id_pend_d;
      din_pend_q  <= din_pend_d;
      meta_pend_q <= meta_pend_d;
      mvalid_q    <= mvalid_d;
      mdata_q     <= mdata_d;
      mlast_q     <= mlast_d;
    end
  end

  spi_word_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (flush),
    .load_i   (ser_load),
    .data_i   (ser_data),
    .keep_i   (ser_keep),
    .tready_i (tx_tready),
    .tvalid_o (ser_tvalid),
    .tdata_o  (ser_tdata),
    .done_o   (ser_done)
  );

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - self-checking bench for spi_tx_arbiter
module tb_spi_tx_arbiter;

  localparam logic [31:0] ID_EXP = 32'h534C4131;

  logic        clk = 1'b0;
  logic        rst, flush, query_id, query_dataIn, query_metadata;
  logic [31:0] dataIn;
  logic        meta_tvalid, meta_tlast, meta_tready;
  logic [7:0]  meta_tdata;
  logic        mem_tvalid, mem_tready;
  logic [31:0] mem_tdata;
  logic [3:0]  mem_tkeep;
  logic        tx_tvalid, tx_tready, busy;
  logic [7:0]  tx_tdata;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          stall_cnt = 0;
  logic [7:0]  got_q[$];
  int          got_t[$];
  logic [7:0]  expq[$];
  logic [35:0] mem_src[$];
  logic [8:0]  meta_src[$];
  logic        mem_hs = 1'b0;
  logic        meta_hs = 1'b0;
  logic        stall_q = 1'b0;
  logic [7:0]  stall_data = 8'h00;

  typedef struct {
    string       name;
    int          src;    // 0 id, 1 dataIn, 2 mem
    logic [31:0] word;
    logic [3:0]  keep;
    int          rdy;
    int          n;
    logic [31:0] exp;    // expected bytes, first byte in bits 7:0
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  spi_tx_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .query_id(query_id), .query_dataIn(query_dataIn), .query_metadata(query_metadata),
    .dataIn(dataIn),
    .meta_tvalid(meta_tvalid), .meta_tdata(meta_tdata), .meta_tlast(meta_tlast), .meta_tready(meta_tready),
    .mem_tvalid(mem_tvalid), .mem_tdata(mem_tdata), .mem_tkeep(mem_tkeep), .mem_tready(mem_tready),
    .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tready(tx_tready),
    .busy(busy)
  );

  // tx_tready pattern: 0 always, 1 toggling, 2 random, 3 ready one cycle in three
  initial begin
    tx_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tx_tready = 1'b1;
        1: tx_tready = ~tx_tready;
        2: tx_tready = ($urandom_range(0, 2) != 0);
        default: begin
          stall_cnt = (stall_cnt + 1) % 3;
          tx_tready = (stall_cnt == 0);
        end
      endcase
    end
  end

  // Memory and metadata sources present the head of their queues.
  initial begin
    mem_tvalid = 1'b0; mem_tdata = 32'h0; mem_tkeep = 4'h0;
    meta_tvalid = 1'b0; meta_tdata = 8'h00; meta_tlast = 1'b0;
    forever begin
      @(posedge clk);
      if (mem_hs && mem_src.size() != 0) void'(mem_src.pop_front());
      if (meta_hs && meta_src.size() != 0) void'(meta_src.pop_front());
      #1;
      mem_tvalid = (mem_src.size() != 0);
      if (mem_tvalid) {mem_tkeep, mem_tdata} = mem_src[0];
      meta_tvalid = (meta_src.size() != 0);
      if (meta_tvalid) {meta_tlast, meta_tdata} = meta_src[0];
    end
  end

  // Byte monitor and hold-while-stalled checker, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    cyc++;
    mem_hs  = mem_tvalid && mem_tready;
    meta_hs = meta_tvalid && meta_tready;
    if (stall_q) begin
      checks++;
      if (!tx_tvalid || tx_tdata != stall_data) begin
        errors++;
        $display("FAIL hold: tx_tvalid=%0b tx_tdata=%02h, required 1/%02h", tx_tvalid, tx_tdata, stall_data);
      end
    end
    stall_q    = tx_tvalid && !tx_tready && !rst && !flush;
    stall_data = tx_tdata;
    if (tx_tvalid && tx_tready && !rst) begin
      got_q.push_back(tx_tdata);
      got_t.push_back(cyc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick();
    while ((busy || tx_tvalid || mem_src.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk({name, " done"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    chk({name, " count"}, 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk($sformatf("%s byte%0d", name, i), 32'(got_q[i]), 32'(exp[i]));
    got_q.delete();
    got_t.delete();
  endtask

  task automatic pulse(input logic id, input logic din, input logic md);
    query_id = id; query_dataIn = din; query_metadata = md;
    tick();
    query_id = 1'b0; query_dataIn = 1'b0; query_metadata = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) expq.push_back(w[8*b +: 8]);
  endtask

  initial begin
    int          n;
    int          kind;
    int          nw;
    int          len;
    logic        pid, pdin, pmd;
    logic [31:0] w;
    logic [3:0]  k;
    logic [7:0]  b8;

    rst = 1'b1; flush = 1'b0;
    query_id = 1'b0; query_dataIn = 1'b0; query_metadata = 1'b0;
    dataIn = 32'h0;

    vecs[0] = '{"id_ready",  0, 32'h0,        4'h0, 0, 4, ID_EXP};
    vecs[1] = '{"id_toggle", 0, 32'h0,        4'h0, 1, 4, ID_EXP};
    vecs[2] = '{"mem_keepA", 2, 32'hDDCCBBAA, 4'hA, 1, 2, 32'h0000DDBB};
    vecs[3] = '{"mem_full",  2, 32'h11223344, 4'hF, 2, 4, 32'h11223344};
    vecs[4] = '{"mem_keep0", 2, 32'hAABBCCDD, 4'h0, 0, 0, 32'h0};
    vecs[5] = '{"mem_lane0", 2, 32'hAABBCCDD, 4'h1, 3, 1, 32'h000000DD};
    vecs[6] = '{"mem_lane3", 2, 32'h80FF00FF, 4'h8, 0, 1, 32'h00000080};
    vecs[7] = '{"mem_keep6", 2, 32'h01020304, 4'h6, 0, 2, 32'h00000203};
    vecs[8] = '{"din",       1, 32'h12345678, 4'h0, 2, 4, 32'h12345678};

    tick(3);
    chk("rst tx_tvalid", 32'(tx_tvalid), 32'd0);
    chk("rst tx_tdata", 32'(tx_tdata), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst meta_tready", 32'(meta_tready), 32'd0);
    chk("rst mem_tready", 32'(mem_tready), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle mem_tready", 32'(mem_tready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      rdy_mode = vecs[i].rdy;
      case (vecs[i].src)
        0: pulse(1'b1, 1'b0, 1'b0);
        1: begin dataIn = vecs[i].word; pulse(1'b0, 1'b1, 1'b0); end
        default: mem_src.push_back({vecs[i].keep, vecs[i].word});
      endcase
      wait_idle(vecs[i].name);
      chk({vecs[i].name, " busy"}, 32'(busy), 32'd0);
      if (vecs[i].rdy == 0 && vecs[i].n > 1 && got_t.size() == vecs[i].n)
        chk({vecs[i].name, " gap"}, 32'(got_t[vecs[i].n-1] - got_t[0]), 32'(vecs[i].n - 1));
      expq.delete();
      for (int b = 0; b < vecs[i].n; b++) expq.push_back(vecs[i].exp[8*b +: 8]);
      check_bytes(vecs[i].name, expq);
    end

    // Simultaneous ID and dataIn queries: ID wins, dataIn follows.
    rdy_mode = 0;
    dataIn = 32'h12345678;
    pulse(1'b1, 1'b1, 1'b0);
    wait_idle("id_din");
    expq.delete(); push_word(ID_EXP); push_word(32'h12345678);
    check_bytes("id_din", expq);

    // Repeated query while pending yields a single response.
    query_id = 1'b1; tick(2); query_id = 1'b0;
    wait_idle("sticky");
    expq.delete(); push_word(ID_EXP);
    check_bytes("sticky", expq);

    // Metadata pass-through with stalls; the byte after tlast must stay in the source.
    rdy_mode = 3;
    meta_src.push_back({1'b0, 8'hA1}); meta_src.push_back({1'b0, 8'hB2});
    meta_src.push_back({1'b1, 8'hC3}); meta_src.push_back({1'b0, 8'hD4});
    pulse(1'b0, 1'b0, 1'b1);
    wait_idle("meta");
    chk("meta leftover", 32'(meta_src.size()), 32'd1);
    meta_src.delete();
    expq.delete(); expq.push_back(8'hA1); expq.push_back(8'hB2); expq.push_back(8'hC3);
    check_bytes("meta", expq);

    // dataIn query on the memory handshake cycle, memory held valid throughout.
    rdy_mode = 2;
    dataIn = 32'hCAFEF00D;
    mem_src.push_back({4'hF, 32'h01020304});
    mem_src.push_back({4'hF, 32'hA0B0C0D0});
    tick();
    chk("hs mem_tready", 32'(mem_tready && mem_tvalid), 32'd1);
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle("mem_din");
    expq.delete(); push_word(32'h01020304); push_word(32'hCAFEF00D); push_word(32'hA0B0C0D0);
    check_bytes("mem_din", expq);

    // Flush in the cycle the second ID byte is accepted.
    rdy_mode = 0;
    pulse(1'b1, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_tvalid && tx_tready && tx_tdata == 8'h41) && n < 50);
    chk("flush reach", 32'(n < 50), 32'd1);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    chk("flush tx_tvalid", 32'(tx_tvalid), 32'd0);
    chk("flush busy", 32'(busy), 32'd0);
    tick(10);
    expq.delete(); expq.push_back(8'h31); expq.push_back(8'h41);
    check_bytes("flush", expq);

    // Flush-coincident query is discarded.
    flush = 1'b1; query_dataIn = 1'b1;
    tick();
    flush = 1'b0; query_dataIn = 1'b0;
    tick(5);
    chk("flush query busy", 32'(busy), 32'd0);
    expq.delete();
    check_bytes("flush query", expq);

    // Reset in the middle of a response.
    pulse(1'b1, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_tvalid && tx_tready) && n < 50);
    @(posedge clk); #2;
    rst = 1'b1;
    tick();
    chk("midrst mem_tready", 32'(mem_tready), 32'd0);
    rst = 1'b0;
    tick(10);
    chk("midrst busy", 32'(busy), 32'd0);
    expq.delete(); expq.push_back(8'h31);
    check_bytes("midrst", expq);

    // Randomised rounds against a priority-order byte model.
    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(0, 3);
      rdy_mode = $urandom_range(0, 3);
      expq.delete();
      if (kind == 0) begin
        nw = $urandom_range(1, 3);
        for (int j = 0; j < nw; j++) begin
          w = $urandom;
          k = 4'($urandom_range(0, 15));
          mem_src.push_back({k, w});
          for (int l = 0; l < 4; l++) if (k[l]) expq.push_back(w[8*l +: 8]);
        end
      end else begin
        pid = 1'($urandom_range(0, 1));
        pdin = 1'($urandom_range(0, 1));
        pmd = 1'($urandom_range(0, 1));
        if (!pid && !pdin) pmd = 1'b1;
        dataIn = $urandom;
        if (pid) push_word(ID_EXP);
        if (pdin) push_word(dataIn);
        if (pmd) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) begin
            b8 = 8'($urandom);
            meta_src.push_back({(j == len - 1), b8});
            expq.push_back(b8);
          end
        end
        pulse(pid, pdin, pmd);
      end
      wait_idle($sformatf("rand%0d", r));
      check_bytes($sformatf("rand%0d", r), expq);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter ID_WORD, default 32'h534C4131, device ID word; sent LSB byte first ('1','A','L','S').
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  soft-reset pulse; abandons current response.
REQ-005 query_id / query_dataIn / query_metadata  input  1 each  single-cycle command pulses.
REQ-006 dataIn  input  32  raw probe inputs, sampled for dataIn response.
REQ-007 meta_tvalid, meta_tdata[7:0], meta_tlast  input; meta_tready  output  metadata byte stream.
REQ-008 mem_tvalid, mem_tdata[31:0], mem_tkeep[3:0]  input; mem_tready  output  captured-sample word stream.
REQ-009 tx_tvalid, tx_tdata[7:0]  output; tx_tready  input  byte stream to SPI transmitter.
REQ-010 busy  output  1  high when state != IDLE or any request pending.

Function
REQ-011 Each query pulse sets a sticky pending flag; pulse while flag already set has no additional effect.
REQ-012 Arbitration only in IDLE, fixed priority: ID > dataIn > metadata > mem.
REQ-013 States: IDLE, WORD (serialize 32-bit holding register under 4-bit keep mask), META (byte pass-through).
REQ-014 IDLE, ID pending: load ID_WORD, keep=4'hF, clear flag, go WORD next cycle.
REQ-015 IDLE, dataIn pending (ID not pending): load dataIn sampled that cycle, keep=4'hF, clear flag, go WORD.
REQ-016 IDLE, metadata highest pending: clear flag, go META.
REQ-017 mem_tready = (state==IDLE) and no flag pending (registered flags only); handshake loads mem_tdata/mem_tkeep, go WORD.
REQ-018 Query pulse coincident with mem handshake: word is served first, query stays pending.
REQ-019 WORD: emit byte lanes 0..3 in ascending order, only lanes with keep bit set; tx_tdata = lane bits, tx_tvalid registered.
REQ-020 tx_tvalid first asserts the cycle after entering WORD; tx_tdata/tx_tvalid held stable until tx_tready sampled high.
REQ-021 After final kept lane accepted, return IDLE next cycle; keep==4'h0 word consumed, no bytes, back to IDLE.
REQ-022 Back-to-back: mem_tready may reassert the cycle after return to IDLE; min 1 idle cycle between responses.
REQ-023 META: meta_tready = tx_tready or !tx_tvalid (single-entry skid register); bytes forwarded in order, unmodified.
REQ-024 META exits to IDLE after the byte with meta_tlast is accepted on tx side.
REQ-025 flush: next cycle state=IDLE, all pending flags cleared, tx_tvalid=0; a flush-coincident query pulse is discarded.
REQ-026 No byte duplicated or dropped under arbitrary tx_tready stalls.

Reset
REQ-027 On rst: state=IDLE, flags=0, tx_tvalid=0, tx_tdata=8'h00, mem_tready=0 during rst, meta_tready=0, busy=0.
REQ-028 rst mid-response: response abandoned, no partial byte re-sent after release.

Structure
REQ-029 Shared package spi_pkg holds ID default constant, state encoding enum, source enum (SRC_ID, SRC_DATAIN, SRC_META, SRC_MEM).
REQ-030 One sub-module spi_word_serializer (32-bit holding reg + keep mask -> byte stream with valid/ready); arbiter FSM in top.

Verification
REQ-031 query_id pulse, tx_tready=1 -> bytes 8'h31,8'h41,8'h4C,8'h53 on consecutive cycles, then busy=0.
REQ-032 mem word 32'hDDCCBBAA keep=4'b1010, tx_tready toggling -> exactly 8'hBB then 8'hDD, each held until accepted.
REQ-033 query_id and query_dataIn same cycle, dataIn=32'h12345678 -> ID 4 bytes then 8'h78,8'h56,8'h34,8'h12.
REQ-034 query_metadata, meta stream 3 bytes (tlast on third), tx_tready stalled 2 cycles per byte -> 3 bytes in order, META exits, IDLE.
REQ-035 mem_tvalid held high with query_dataIn pulse on handshake cycle -> current word sent, dataIn response next, mem_tready low until done.
REQ-036 flush after 2nd ID byte -> tx_tvalid=0 next cycle, no further bytes, busy=0.
